// File: rtl/aes_byte_display_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_display_if
// Brief    : Bus between the AES result source and the byte display stage.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_byte_display_if;
    logic [0:127] dataIn;
    logic         dataValid;
    logic         nextByte;
    logic         autoScan;
    logic [3:0]   byteIdx;
    logic [20:0]  segOut;
    logic         busy;

    modport master (
        output dataIn,
        output dataValid,
        output nextByte,
        output autoScan,
        input  byteIdx,
        input  segOut,
        input  busy
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        input  nextByte,
        input  autoScan,
        output byteIdx,
        output segOut,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_byte_display.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_display
// Brief    : Steps through the bytes of a captured AES block and shows each one
//            as three decimal seven-segment digits (sequential double-dabble).
// Revision : 1.0 - initial release
// ============================================================================
module aes_byte_display #(
    parameter int SCAN_DIV  = 50000000,
    parameter int NUM_BYTES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_byte_display_if.slave bus
);

    localparam int                 c_CNT_W     = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]         c_LAST_IDX  = 4'(NUM_BYTES - 1);
    localparam logic [6:0]         c_BLANK     = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;

    logic [0:127]        r_block;
    logic                r_loaded;
    logic [3:0]          r_byteIdx;
    logic [20:0]         r_segOut;
    logic [c_CNT_W-1:0]  r_scanCnt;
    logic [7:0]          r_shift;
    logic [9:0]          r_bcd;     // {hundreds[1:0], tens[3:0], ones[3:0]}
    logic [2:0]          r_step;

    logic                w_tick;
    logic                w_advance;
    logic                w_start;
    logic [3:0]          w_nextIdx;
    logic [6:0]          w_bitBase;
    logic [7:0]          w_startByte;
    logic [3:0]          w_tensAdj;
    logic [3:0]          w_onesAdj;
    logic [3:0]          w_hund;
    logic [3:0]          w_tens;
    logic [3:0]          w_ones;
    logic [6:0]          w_hundSeg;
    logic [6:0]          w_tensSeg;
    logic [6:0]          w_onesSeg;

    function automatic logic [3:0] addThree(input logic [3:0] nib);
        return (nib > 4'd4) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] segEncode(input logic [3:0] dig);
        logic [6:0] seg;
        case (dig)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = c_BLANK;
        endcase
        return seg;
    endfunction

    // Advances are only honoured when idle; dataValid pre-empts everything.
    assign w_tick      = bus.autoScan && r_loaded && (r_scanCnt == c_SCAN_LAST);
    assign w_advance   = (bus.nextByte || w_tick) && r_loaded &&
                         (r_state == S_IDLE) && !bus.dataValid;
    assign w_start     = bus.dataValid || w_advance;
    assign w_nextIdx   = (r_byteIdx == c_LAST_IDX) ? 4'd0 : r_byteIdx + 4'd1;
    assign w_bitBase   = {w_nextIdx, 3'b000};
    assign w_startByte = bus.dataValid ? bus.dataIn[0:7] : r_block[w_bitBase +: 8];

    // The hundreds digit never exceeds 2, so it needs no add-3 correction.
    assign w_tensAdj   = addThree(r_bcd[7:4]);
    assign w_onesAdj   = addThree(r_bcd[3:0]);

    assign w_hund      = {2'b00, r_bcd[9:8]};
    assign w_tens      = r_bcd[7:4];
    assign w_ones      = r_bcd[3:0];
    assign w_hundSeg   = (w_hund == 4'd0) ? c_BLANK : segEncode(w_hund);
    assign w_tensSeg   = ((w_hund == 4'd0) && (w_tens == 4'd0)) ? c_BLANK : segEncode(w_tens);
    assign w_onesSeg   = segEncode(w_ones);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stateNext = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_step == 3'd7) begin
                    w_stateNext = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
        if (bus.dataValid) begin
            w_stateNext = S_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block   <= '0;
            r_loaded  <= 1'b0;
            r_byteIdx <= 4'd0;
            r_segOut  <= 21'h1FFFFF;
            r_shift   <= 8'd0;
            r_bcd     <= 10'd0;
            r_step    <= 3'd0;
        end else begin
            if (bus.dataValid) begin
                r_block   <= bus.dataIn;
                r_loaded  <= 1'b1;
                r_byteIdx <= 4'd0;
            end else if (w_advance) begin
                r_byteIdx <= w_nextIdx;
            end

            if (w_start) begin
                r_shift <= w_startByte;
                r_bcd   <= 10'd0;
                r_step  <= 3'd0;
            end else if (r_state == S_SHIFT) begin
                r_bcd   <= {r_bcd[8], w_tensAdj, w_onesAdj, r_shift[7]};
                r_shift <= {r_shift[6:0], 1'b0};
                r_step  <= r_step + 3'd1;
            end

            if ((r_state == S_UPDATE) && !bus.dataValid) begin
                r_segOut <= {w_hundSeg, w_tensSeg, w_onesSeg};
            end
        end
    end

    // A tick dropped while busy still reloads the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scanCnt <= '0;
        end else if (bus.dataValid || !(bus.autoScan && r_loaded)) begin
            r_scanCnt <= '0;
        end else if (r_scanCnt == c_SCAN_LAST) begin
            r_scanCnt <= '0;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
        end
    end

    assign bus.byteIdx = r_byteIdx;
    assign bus.segOut  = r_segOut;
    assign bus.busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/aes_byte_display.md
Name: aes_byte_display

Overview:
- Display stage directly downstream of the AES top-level.
- Captures a finished 128-bit cipher/plain result and steps through its 16 bytes, manually or automatically.
- Converts the selected byte to 3 decimal digits using a sequential 8-step shift-add-3 engine.
- Drives three static active-low seven-segment digits in the same 21-bit packing the top-level uses.

Parameters:
- SCAN_DIV, 50000000: clock cycles between automatic byte advances when autoScan=1; legal minimum 2.
- NUM_BYTES, 16: bytes per block; byteIdx wraps at NUM_BYTES-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- dataIn  input  [0:127]  result block; byte k = dataIn[8k +: 8], so byte 0 = dataIn[0:7].
- dataValid  input  1  single-cycle pulse: capture dataIn and display byte 0.
- nextByte  input  1  single-cycle pulse: advance to next byte.
- autoScan  input  1  level: advance one byte every SCAN_DIV cycles.
- byteIdx  output  4  index of the displayed or converting byte.
- segOut  output  21  [6:0] ones, [13:7] tens, [20:14] hundreds; active-low segments {g,f,e,d,c,b,a}.
- busy  output  1  high while a conversion is in flight.

Behaviour:
- Reset (async, rst_n=0): captured block=0, loaded=0, byteIdx=0, segOut=21'h1FFFFF (all blank), busy=0, scan counter=0, FSM=IDLE. Outputs stay at reset values until rst_n deasserts.
- FSM states: IDLE, SHIFT, UPDATE.
  - Start event: IDLE -> SHIFT. Load the BCD register with 0 and the shift register with the selected byte; step count=0.
  - SHIFT, 8 cycles, one bit per cycle, MSB first: add 3 to each BCD nibble >4, then shift left one bit. After the 8th shift -> UPDATE.
  - UPDATE: register the encoded digits into segOut -> IDLE.
  - busy=1 in SHIFT and UPDATE.
- Latency: start event sampled at edge E0; segOut updates at edge E9; busy falls at edge E9. segOut holds its previous value during conversion.
- Start event sources, priority dataValid > nextByte > auto tick:
  - dataValid: capture dataIn, byteIdx<=0, loaded<=1, start. Allowed in any state; aborts an in-flight conversion and restarts it. The scan counter clears.
  - nextByte: acted on only in IDLE with loaded=1. byteIdx<=byteIdx+1, wrapping NUM_BYTES-1 -> 0, then start. Pulses while busy or before the first load are dropped, not queued.
  - Auto tick: the counter increments each cycle while autoScan=1 and loaded=1. At SCAN_DIV-1 it generates a tick and returns to 0. A tick behaves as nextByte, including being dropped while busy; the counter still reloads. autoScan=0 holds the counter at 0.
  - Simultaneous nextByte and tick: advance exactly once.
- Digit encoding, values 0..255:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Leading-zero blanking: hundreds=1111111 if 0; tens=1111111 if hundreds and tens are both 0. Ones always shown.
- byteIdx changes at the start-event edge, so it leads segOut by 9 cycles.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT -> immediately segOut=1FFFFF, busy=0, byteIdx=0; release, run 20 cycles -> nothing changes (loaded=0). Then nextByte -> ignored.
- Load: dataIn=128'h3ad77bb40d7a3660a89ecaf32466ef97, dataValid pulse.
  - busy high for 9 cycles; byteIdx=0.
  - segOut after E9 = {1111111, 0010010, 0000000}, i.e. 58 (0x3a).
- Step and wrap:
  - nextByte -> byteIdx=1, display 215 = {0100100, 1111001, 0010010}.
  - Continue to byteIdx=15 -> 0x97=151 = {1111001, 0010010, 1111001}.
  - One more nextByte -> byteIdx=0, 58.
- Zero and blanking:
  - dataIn=0, dataValid -> segOut={1111111, 1111111, 1000000}.
  - Byte 0x05 -> {1111111, 1111111, 0010010}.
  - Byte 0x64=100 -> {1111001, 1000000, 1000000}.
- Collisions:
  - nextByte 3 cycles after dataValid (busy) -> dropped; byteIdx stays 0.
  - dataValid with a new block mid-SHIFT -> conversion restarts; segOut reflects the new byte 0 nine cycles after the second pulse.
  - dataValid and nextByte in the same cycle -> byteIdx=0.
- Auto scan: SCAN_DIV=12, autoScan=1 after load -> byteIdx advances every 12 cycles, 0->1->2. With SCAN_DIV=4 (< conversion time), every tick that lands while busy is dropped.
